// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: request, response and RAM signals of the VRAM arbiter.
// Modports:
//   slave  - the arbiter: takes video/game/clear requests and RAM read data,
//            drives grants, read data/valids, clear status and RAM controls.
//   master - the surrounding requesters and RAM.
interface vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
);
    logic              vid_rd_req;
    logic [ADDR_W-1:0] vid_rd_addr;
    logic [DATA_W-1:0] vid_rd_data;
    logic              vid_rd_valid;
    logic              gl_req;
    logic              gl_we;
    logic [ADDR_W-1:0] gl_addr;
    logic [DATA_W-1:0] gl_wdata;
    logic              gl_ack;
    logic [DATA_W-1:0] gl_rdata;
    logic              gl_rvalid;
    logic              clr_start;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              clr_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    modport slave (
        input  vid_rd_req, vid_rd_addr, gl_req, gl_we, gl_addr, gl_wdata,
               clr_start, clr_color, mem_rdata,
        output vid_rd_data, vid_rd_valid, gl_ack, gl_rdata, gl_rvalid,
               clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output vid_rd_req, vid_rd_addr, gl_req, gl_we, gl_addr, gl_wdata,
               clr_start, clr_color, mem_rdata,
        input  vid_rd_data, vid_rd_valid, gl_ack, gl_rdata, gl_rvalid,
               clr_busy, clr_done, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM (1-cycle read latency) between
// video scanout (highest priority), an optional screen-clear engine and the
// game-logic port. The clear engine is built only when VRAM_CLEAR_EN is defined.
// Ports:
//   clk     - system clock
//   reset_n - synchronous reset, active low
//   bus     - vram_arbiter_if.slave: video read, game read/write, clear
//             control/status and the registered RAM interface
module vram_arbiter #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 12,
    parameter int CLR_LAST = 29999
) (
    input logic           clk,
    input logic           reset_n,
    vram_arbiter_if.slave bus
);
    logic              idle, clr_wr, gl_ack;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    // read-source tags {video, game}; stage 2 lines up with returning RAM data
    logic [1:0]        tag1_q, tag1_d, tag2_q;

`ifdef VRAM_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] color_q, color_d;
    logic              done_q, done_d, last;

    assign idle         = state_q == IDLE;
    assign clr_wr       = state_q == CLEAR && !bus.vid_rd_req;
    assign last         = cnt_q == ADDR_W'(CLR_LAST);
    assign clr_addr     = cnt_q;
    assign clr_data     = color_q;
    assign bus.clr_busy = state_q == CLEAR;
    assign bus.clr_done = done_q;

    // counter holds at the last address so it can never wrap
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        color_d = color_q;
        done_d  = 1'b0;
        if (idle && bus.clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
            color_d = bus.clr_color;
        end else if (clr_wr) begin
            state_d = last ? IDLE : CLEAR;
            cnt_d   = last ? cnt_q : cnt_q + 1'b1;
            done_d  = last;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            color_q <= color_d;
            done_q  <= done_d;
        end
    end
`else
    logic unused_clr;

    assign unused_clr   = ^{bus.clr_start, bus.clr_color, CLR_LAST[0]};
    assign idle         = 1'b1;
    assign clr_wr       = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
    assign bus.clr_busy = 1'b0;
    assign bus.clr_done = 1'b0;
`endif

    // no grant while in reset, so a request is never acked without its access
    assign gl_ack = reset_n && bus.gl_req && !bus.vid_rd_req && idle;

    always_comb begin
        mem_en_d    = bus.vid_rd_req || clr_wr || gl_ack;
        mem_we_d    = bus.vid_rd_req ? 1'b0 : clr_wr ? 1'b1 : gl_ack ? bus.gl_we : mem_we_q;
        mem_addr_d  = bus.vid_rd_req ? bus.vid_rd_addr : clr_wr ? clr_addr :
                      gl_ack ? bus.gl_addr : mem_addr_q;
        mem_wdata_d = clr_wr ? clr_data : gl_ack ? bus.gl_wdata : mem_wdata_q;
        tag1_d      = {bus.vid_rd_req, gl_ack && !bus.gl_we};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag1_q      <= '0;
            tag2_q      <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            tag1_q      <= tag1_d;
            tag2_q      <= tag1_q;
        end
    end

    assign bus.gl_ack       = gl_ack;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.vid_rd_data  = bus.mem_rdata;
    assign bus.gl_rdata     = bus.mem_rdata;
    assign bus.vid_rd_valid = tag2_q[1];
    assign bus.gl_rvalid    = tag2_q[0];
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector bench for vram_arbiter with a RAM model whose
// word at address a starts as ~a[11:0].
module tb_vram_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    logic ram_init;
    logic [11:0] ram [0:32767];
    logic [11:0] rdata = 12'h000;
    int checks = 0;
    int failures = 0;
    int vreq, vval, both, done_cnt, ack_busy, bad;
    bit acked, found;

    vram_arbiter_if #(.ADDR_W(15), .DATA_W(12)) bus ();

    vram_arbiter dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 32768; i++) ram[i] <= ~12'(i);
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            else rdata <= ram[bus.mem_addr];
        end
    end
    assign bus.mem_rdata = rdata;

    typedef struct {
        logic        vid;
        logic [14:0] vaddr;
        logic        gl;
        logic        we;
        logic [14:0] gaddr;
        logic [11:0] gdata;
        logic        ack;
        logic        en;
        logic        mwe;
        logic [14:0] maddr;
        logic [11:0] mwdata;
        logic        vv;
        logic        gv;
        logic [11:0] rd;
    } vec_t;
    vec_t tbl [17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.vid_rd_req  = 1'b0;
        bus.vid_rd_addr = 15'h0000;
        bus.gl_req      = 1'b0;
        bus.gl_we       = 1'b0;
        bus.gl_addr     = 15'h0000;
        bus.gl_wdata    = 12'h000;
        bus.clr_start   = 1'b0;
        bus.clr_color   = 12'h000;
    endtask

    initial begin
        //        vid  vaddr      gl   we   gaddr      gdata    ack  en   mwe  maddr      mwdata   vv   gv   rdata
        tbl[0]  = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,12'h000};
        tbl[1]  = '{1'b1,15'h0123,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,12'h000};
        tbl[2]  = '{1'b1,15'h0200,1'b1,1'b1,15'h0040,12'hF00, 1'b0,1'b1,1'b0,15'h0123,12'h000, 1'b0,1'b0,12'h000};
        tbl[3]  = '{1'b0,15'h0000,1'b1,1'b1,15'h0040,12'hF00, 1'b1,1'b1,1'b0,15'h0200,12'h000, 1'b1,1'b0,12'hEDC};
        tbl[4]  = '{1'b0,15'h0000,1'b1,1'b0,15'h0040,12'h000, 1'b1,1'b1,1'b1,15'h0040,12'hF00, 1'b1,1'b0,12'hDFF};
        tbl[5]  = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b1,1'b0,15'h0040,12'h000, 1'b0,1'b0,12'h000};
        tbl[6]  = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,1'b0,15'h0040,12'h000, 1'b0,1'b1,12'hF00};
        tbl[7]  = '{1'b1,15'h7FFF,1'b1,1'b0,15'h0123,12'h000, 1'b0,1'b0,1'b0,15'h0040,12'h000, 1'b0,1'b0,12'h000};
        tbl[8]  = '{1'b0,15'h0000,1'b1,1'b0,15'h0123,12'h000, 1'b1,1'b1,1'b0,15'h7FFF,12'h000, 1'b0,1'b0,12'h000};
        tbl[9]  = '{1'b1,15'h0001,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b1,1'b0,15'h0123,12'h000, 1'b1,1'b0,12'h000};
        tbl[10] = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b1,1'b0,15'h0001,12'h000, 1'b0,1'b1,12'hEDC};
        tbl[11] = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,1'b0,15'h0001,12'h000, 1'b1,1'b0,12'hFFE};
        tbl[12] = '{1'b0,15'h0000,1'b1,1'b1,15'h7FFF,12'h0AB, 1'b1,1'b0,1'b0,15'h0001,12'h000, 1'b0,1'b0,12'h000};
        tbl[13] = '{1'b0,15'h0000,1'b1,1'b0,15'h7FFF,12'h000, 1'b1,1'b1,1'b1,15'h7FFF,12'h0AB, 1'b0,1'b0,12'h000};
        tbl[14] = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b1,1'b0,15'h7FFF,12'h000, 1'b0,1'b0,12'h000};
        tbl[15] = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,1'b0,15'h7FFF,12'h000, 1'b0,1'b1,12'h0AB};
        tbl[16] = '{1'b0,15'h0000,1'b0,1'b0,15'h0000,12'h000, 1'b0,1'b0,1'b0,15'h7FFF,12'h000, 1'b0,1'b0,12'h000};

        reset_n  = 1'b0;
        ram_init = 1'b1;
        idle_inputs();
        tick();
        ram_init = 1'b0;
        tick();
        reset_n = 1'b1;

        // reset state and quiet outputs
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("rst_mem_c%0d", i), {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}, 32'h0);
            chk($sformatf("rst_ctl_c%0d", i),
                {bus.vid_rd_valid, bus.gl_rvalid, bus.gl_ack, bus.clr_busy, bus.clr_done}, 32'h0);
        end

        // arbitration and read/write timing vectors
        for (int i = 0; i < 17; i++) begin
            tick();
            bus.vid_rd_req  = tbl[i].vid;
            bus.vid_rd_addr = tbl[i].vaddr;
            bus.gl_req      = tbl[i].gl;
            bus.gl_we       = tbl[i].we;
            bus.gl_addr     = tbl[i].gaddr;
            bus.gl_wdata    = tbl[i].gdata;
            #1;
            chk($sformatf("v%0d_ack", i), bus.gl_ack, tbl[i].ack);
            chk($sformatf("v%0d_mem", i), {bus.mem_en, bus.mem_we, bus.mem_addr},
                {tbl[i].en, tbl[i].mwe, tbl[i].maddr});
            if (tbl[i].mwe) chk($sformatf("v%0d_wdata", i), bus.mem_wdata, tbl[i].mwdata);
            chk($sformatf("v%0d_vvalid", i), bus.vid_rd_valid, tbl[i].vv);
            chk($sformatf("v%0d_gvalid", i), bus.gl_rvalid, tbl[i].gv);
            if (tbl[i].vv) chk($sformatf("v%0d_vdata", i), bus.vid_rd_data, tbl[i].rd);
            if (tbl[i].gv) chk($sformatf("v%0d_gdata", i), bus.gl_rdata, tbl[i].rd);
        end

        // reset right after a video read is issued: its valid must never appear
        tick();
        idle_inputs();
        bus.vid_rd_req  = 1'b1;
        bus.vid_rd_addr = 15'h0123;
        tick();
        idle_inputs();
        reset_n = 1'b0;
        #1;
        chk("flush_issued", bus.mem_en, 1'b1);
        tick();
        reset_n = 1'b1;
        chk("flush_en", bus.mem_en, 1'b0);
        chk("flush_valid1", {bus.vid_rd_valid, bus.gl_rvalid}, 2'b00);
        tick();
        chk("flush_valid2", {bus.vid_rd_valid, bus.gl_rvalid}, 2'b00);

`ifdef VRAM_CLEAR_EN
        // full clear with periodic video reads and a held game read
        vreq = 0; vval = 0; both = 0; done_cnt = 0; ack_busy = 0; acked = 1'b0;
        tick();
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h00F;
        #1;
        chk("clr_pre_busy", bus.clr_busy, 1'b0);
        for (int k = 1; k < 50000 && !acked; k++) begin
            tick();
            if (k == 1) chk("clr_busy_rise", bus.clr_busy, 1'b1);
            if (k == 2) chk("clr_first_wr", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                            {1'b1, 1'b1, 15'h0000, 12'h00F});
            if (bus.vid_rd_valid) vval++;
            if (bus.vid_rd_valid && bus.gl_rvalid) both++;
            if (bus.clr_done) done_cnt++;
            bus.clr_start   = (k == 100);
            bus.clr_color   = (k == 100) ? 12'h0F0 : 12'h00F;
            bus.vid_rd_req  = (k % 4 == 0) && done_cnt == 0;
            bus.vid_rd_addr = 15'(k);
            if (bus.vid_rd_req) vreq++;
            bus.gl_req  = 1'b1;
            bus.gl_we   = 1'b0;
            bus.gl_addr = 15'h0005;
            #1;
            if (bus.gl_ack && (bus.clr_busy || done_cnt == 0)) ack_busy++;
            acked = bus.gl_ack;
        end
        chk("clr_gl_acked", acked, 1'b1);
        idle_inputs();
        tick();
        if (bus.vid_rd_valid) vval++;
        if (bus.clr_done) done_cnt++;
        tick();
        if (bus.vid_rd_valid) vval++;
        chk("clr_gl_rvalid", bus.gl_rvalid, 1'b1);
        chk("clr_gl_rdata", bus.gl_rdata, 12'h00F);
        chk("clr_ack_while_busy", ack_busy, 0);
        chk("clr_done_pulses", done_cnt, 1);
        chk("clr_vid_served", vval, vreq);
        chk("clr_both_valid", both, 0);
        bad = 0;
        for (int a = 0; a < 30000; a++) if (ram[a] !== 12'h00F) bad++;
        chk("clr_ram_fill", bad, 0);
        chk("clr_ram_past_last", ram[30000], 12'hACF);

        // reset in the middle of a clear, then restart from address 0
        tick();
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h3C3;
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            tick();
            bus.clr_start = 1'b0;
            found = bus.mem_en && bus.mem_we && bus.mem_addr == 15'd99;
        end
        chk("mid_reach_99", found, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("mid_rst_busy", bus.clr_busy, 1'b0);
        chk("mid_rst_en", bus.mem_en, 1'b0);
        reset_n = 1'b1;
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h555;
        tick();
        bus.clr_start = 1'b0;
        chk("restart_busy", bus.clr_busy, 1'b1);
        tick();
        chk("restart_first_wr", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata},
            {1'b1, 1'b1, 15'h0000, 12'h555});
`else
        // without the clear engine, clr_start is ignored and game keeps access
        tick();
        bus.clr_start = 1'b1;
        bus.clr_color = 12'h00F;
        bus.gl_req    = 1'b1;
        bus.gl_addr   = 15'h0005;
        #1;
        chk("noclr_ack0", bus.gl_ack, 1'b1);
        tick();
        bus.clr_start = 1'b0;
        #1;
        chk("noclr_ack1", bus.gl_ack, 1'b1);
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("noclr_status_c%0d", i), {bus.clr_busy, bus.clr_done}, 2'b00);
        end
`endif
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
